// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master shift engine.
//   - spi_state_t : FSM encoding (IDLE / XFER / FINISH)
//   - CPOL/CPHA/DATA_WIDTH defaults
//   - cnt_width() : width of a counter that must hold 0..DATA_WIDTH
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_FINISH = 2'd2
    } spi_state_t;

    localparam int   DATA_WIDTH_DEFAULT = 8;
    localparam logic CPOL_DEFAULT       = 1'b0;
    localparam logic CPHA_DEFAULT       = 1'b0;

    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/spi_master_core.sv
// spi_master_core: SPI master shift engine for one DATA_WIDTH-bit full-duplex
// transfer (MSB first) per accepted start. SCLK timing comes from an external
// prescaler: this block raises presc_en and edge-detects the returned
// pres_clk level in the clk domain.
//
// Ports:
//   clk, rst        system clock; asynchronous active-low reset
//   start, tx_data  transfer request and word to send
//   pres_clk        prescaler output level (0 while presc_en is low)
//   presc_en        prescaler enable
//   busy, done      status; done pulses for one cycle when rx_data updates
//   rx_data         last received word
//   sclk, mosi,     SPI bus
//   miso, cs_n
//   state_dbg       current FSM state (spi_state_t encoding)
//
// Handshake: start is a level request, sampled only while busy is low. The
// cycle start is seen high in IDLE, tx_data is captured and busy rises; any
// start while busy is ignored (nothing queued). Holding start high chains
// transfers with a CS_n gap of at least one cycle.
import spi_pkg::*;

module spi_master_core #(
    parameter int   DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter logic CPOL       = CPOL_DEFAULT,
    parameter logic CPHA       = CPHA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  pres_clk,
    output logic                  presc_en,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n,
    output logic [1:0]            state_dbg
);

    localparam int CW = cnt_width(DATA_WIDTH);
    // Count value at the final trailing edge. With CPHA=0 the count is bumped
    // on the leading edge, so it already equals DATA_WIDTH at the last TE.
    localparam logic [CW-1:0] FINAL_CNT = CPHA ? CW'(DATA_WIDTH - 1) : CW'(DATA_WIDTH);

    spi_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pres_q;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  en_q, en_d;
    logic                  done_q, done_d;
    logic                  le, te, last_te;

    assign le = (state_q == ST_XFER) &&  pres_clk && !pres_q;
    assign te = (state_q == ST_XFER) && !pres_clk &&  pres_q;
    assign last_te = te && (cnt_q == FINAL_CNT);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        sclk_d  = CPOL;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        en_d    = en_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_XFER;
                    shift_d = tx_data;
                    mosi_d  = tx_data[DATA_WIDTH-1];
                    cs_n_d  = 1'b0;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                sclk_d = CPOL ^ pres_clk;
                if (CPHA == 1'b0) begin
                    // Sampling shifts the word left, so the MSB is always the
                    // next bit to present on the following trailing edge.
                    if (le) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], miso};
                        cnt_d   = cnt_q + CW'(1);
                    end
                    if (te && !last_te) begin
                        mosi_d = shift_q[DATA_WIDTH-1];
                    end
                end else begin
                    if (le) begin
                        mosi_d = shift_q[DATA_WIDTH-1];
                    end
                    if (te) begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], miso};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                // Finishing outputs are loaded on the way into FINISH so done
                // and the cs_n rise are visible during the FINISH cycle.
                if (last_te) begin
                    state_d = ST_FINISH;
                    rx_d    = shift_d;
                    done_d  = 1'b1;
                    en_d    = 1'b0;
                    cs_n_d  = 1'b1;
                    sclk_d  = CPOL;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            pres_q  <= 1'b0;
            sclk_q  <= CPOL;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            pres_q  <= pres_clk;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign presc_en  = en_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign rx_data   = rx_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: two instances (mode 0 and CPOL=1/CPHA=1), each
// with a behavioural prescaler (half period H) and MISO loopback or tie-off.
module tb_spi_master_core;

    localparam int H = 9;
    localparam int W = 8;
    localparam int XFER_CYC = 2 * W * H + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: mode 0 ----------------
    logic         start_a = 1'b0;
    logic [W-1:0] tx_a = '0;
    logic         pres_a, en_a, busy_a, done_a, sclk_a, mosi_a, miso_a, cs_a;
    logic [W-1:0] rx_a;
    logic [1:0]   st_a;
    logic [1:0]   miso_mode_a = 2'd0; // 0 loopback, 1 tie 0, 2 tie 1
    int           pcnt_a;

    assign miso_a = (miso_mode_a == 2'd0) ? mosi_a : (miso_mode_a == 2'd2);

    spi_master_core #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a),
        .pres_clk(pres_a), .presc_en(en_a), .busy(busy_a), .done(done_a),
        .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a),
        .cs_n(cs_a), .state_dbg(st_a)
    );

    // ---------------- instance B: CPOL=1, CPHA=1, MISO tied 1 ----------------
    logic         start_b = 1'b0;
    logic [W-1:0] tx_b = '0;
    logic         pres_b, en_b, busy_b, done_b, sclk_b, mosi_b, cs_b;
    logic [W-1:0] rx_b;
    logic [1:0]   st_b;
    int           pcnt_b;

    spi_master_core #(.DATA_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b),
        .pres_clk(pres_b), .presc_en(en_b), .busy(busy_b), .done(done_b),
        .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b), .miso(1'b1),
        .cs_n(cs_b), .state_dbg(st_b)
    );

    // ---------------- prescaler models ----------------
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_a <= 0; pres_a <= 1'b0;
        end else if (!en_a) begin
            pcnt_a <= 0; pres_a <= 1'b0;
        end else if (pcnt_a == H - 1) begin
            pcnt_a <= 0; pres_a <= ~pres_a;
        end else begin
            pcnt_a <= pcnt_a + 1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_b <= 0; pres_b <= 1'b0;
        end else if (!en_b) begin
            pcnt_b <= 0; pres_b <= 1'b0;
        end else if (pcnt_b == H - 1) begin
            pcnt_b <= 0; pres_b <= ~pres_b;
        end else begin
            pcnt_b <= pcnt_b + 1;
        end
    end

    // ---------------- bus monitors (free-running counters) ----------------
    int           rise_a = 0, done_cnt_a = 0, busy_cyc_a = 0, cs_run_a = 0, gap_a = 0;
    logic [W-1:0] mosi_word_a = '0;
    logic         sclk_prev_a = 1'b0, cs_prev_a = 1'b1;
    int           fall_b = 0, done_cnt_b = 0;
    logic [W-1:0] mosi_word_b = '0;
    logic         sclk_prev_b = 1'b1, cs_prev_b = 1'b1;

    always @(negedge clk) begin
        if (sclk_a && !sclk_prev_a) begin
            rise_a = rise_a + 1;
            if (!cs_prev_a) mosi_word_a = {mosi_word_a[W-2:0], mosi_a};
        end
        if (cs_a) cs_run_a = cs_run_a + 1;
        else begin
            if (cs_prev_a) gap_a = cs_run_a;
            cs_run_a = 0;
        end
        done_cnt_a  = done_cnt_a + int'(done_a);
        busy_cyc_a  = busy_cyc_a + int'(busy_a);
        sclk_prev_a = sclk_a;
        cs_prev_a   = cs_a;

        if (!sclk_b && sclk_prev_b && !cs_prev_b) fall_b = fall_b + 1;
        if (sclk_b && !sclk_prev_b && !cs_prev_b) mosi_word_b = {mosi_word_b[W-2:0], mosi_b};
        done_cnt_b  = done_cnt_b + int'(done_b);
        sclk_prev_b = sclk_b;
        cs_prev_b   = cs_b;
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a && n < 2000);
        if (!done_a) check({name, " done timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done_b(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_b && n < 2000);
        if (!done_b) check({name, " done timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] tx;
        logic [1:0]   miso_mode;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0, d0, b0, f0;

        vecs[0] = '{tx: 8'hA5, miso_mode: 2'd0, exp_rx: 8'hA5};
        vecs[1] = '{tx: 8'h3C, miso_mode: 2'd1, exp_rx: 8'h00};
        vecs[2] = '{tx: 8'h3C, miso_mode: 2'd2, exp_rx: 8'hFF};
        vecs[3] = '{tx: 8'h80, miso_mode: 2'd0, exp_rx: 8'h80};
        vecs[4] = '{tx: 8'h01, miso_mode: 2'd0, exp_rx: 8'h01};

        // reset values
        repeat (3) @(negedge clk);
        check("rst presc_en", 32'(en_a), 32'd0);
        check("rst busy",     32'(busy_a), 32'd0);
        check("rst done",     32'(done_a), 32'd0);
        check("rst rx_data",  32'(rx_a), 32'd0);
        check("rst sclk a",   32'(sclk_a), 32'd0);
        check("rst mosi",     32'(mosi_a), 32'd0);
        check("rst cs_n",     32'(cs_a), 32'd1);
        check("rst sclk b",   32'(sclk_b), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // table-driven mode-0 transfers
        for (int i = 0; i < 5; i++) begin
            r0 = rise_a; d0 = done_cnt_a; b0 = busy_cyc_a;
            miso_mode_a = vecs[i].miso_mode;
            tx_a = vecs[i].tx;
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            check($sformatf("v%0d busy after start", i), 32'(busy_a), 32'd1);
            check($sformatf("v%0d cs_n after start", i), 32'(cs_a), 32'd0);
            wait_done_a($sformatf("v%0d", i));
            check($sformatf("v%0d rx_data", i), 32'(rx_a), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d cs_n with done", i), 32'(cs_a), 32'd1);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d mosi bits", i), 32'(mosi_word_a), 32'(vecs[i].tx));
            check($sformatf("v%0d sclk rises", i), 32'(rise_a - r0), 32'd8);
            check($sformatf("v%0d done pulses", i), 32'(done_cnt_a - d0), 32'd1);
            check_range($sformatf("v%0d busy cycles", i), busy_cyc_a - b0, XFER_CYC - 1, XFER_CYC + 1);
            check($sformatf("v%0d cs_n idle", i), 32'(cs_a), 32'd1);
            check($sformatf("v%0d busy idle", i), 32'(busy_a), 32'd0);
        end

        // start pulsed while busy is ignored
        miso_mode_a = 2'd0;
        d0 = done_cnt_a;
        tx_a = 8'hC3; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (40) @(negedge clk);
        tx_a = 8'hFF; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("ignore");
        check("ignore rx_data", 32'(rx_a), 32'hC3);
        repeat (400) @(negedge clk);
        check("ignore done pulses", 32'(done_cnt_a - d0), 32'd1);
        check("ignore busy", 32'(busy_a), 32'd0);

        // back-to-back with start held high
        r0 = rise_a; d0 = done_cnt_a;
        tx_a = 8'h01; start_a = 1'b1;
        wait_done_a("b2b w0");
        check("b2b rx w0", 32'(rx_a), 32'h01);
        tx_a = 8'h80;
        wait_done_a("b2b w1");
        start_a = 1'b0;
        check("b2b rx w1", 32'(rx_a), 32'h80);
        repeat (4) @(negedge clk);
        check("b2b done pulses", 32'(done_cnt_a - d0), 32'd2);
        check("b2b sclk rises", 32'(rise_a - r0), 32'd16);
        check_range("b2b cs_n gap", gap_a, 1, 10);
        check("b2b mosi w1", 32'(mosi_word_a), 32'h80);
        check("b2b busy idle", 32'(busy_a), 32'd0);

        // reset after 3 bits
        r0 = rise_a; d0 = done_cnt_a;
        tx_a = 8'hF0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 500 && (rise_a - r0) < 3; n++) @(negedge clk);
        check("mid rst 3 bits reached", 32'(rise_a - r0), 32'd3);
        rst = 1'b0;
        #1;
        check("mid rst cs_n", 32'(cs_a), 32'd1);
        check("mid rst presc_en", 32'(en_a), 32'd0);
        check("mid rst sclk", 32'(sclk_a), 32'd0);
        check("mid rst rx_data", 32'(rx_a), 32'd0);
        check("mid rst busy", 32'(busy_a), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid rst no done", 32'(done_cnt_a - d0), 32'd0);
        tx_a = 8'h5A; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("post rst");
        check("post rst rx_data", 32'(rx_a), 32'h5A);

        // mode 3 instance
        repeat (2) @(negedge clk);
        check("m3 sclk idle before", 32'(sclk_b), 32'd1);
        f0 = fall_b; d0 = done_cnt_b;
        tx_b = 8'h3C; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done_b("m3");
        check("m3 rx_data", 32'(rx_b), 32'hFF);
        repeat (2) @(negedge clk);
        check("m3 sclk periods", 32'(fall_b - f0), 32'd8);
        check("m3 mosi bits", 32'(mosi_word_b), 32'h3C);
        check("m3 done pulses", 32'(done_cnt_b - d0), 32'd1);
        check("m3 sclk idle after", 32'(sclk_b), 32'd1);
        check("m3 cs_n idle", 32'(cs_b), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
